// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into 16-bit words and streams them to instruction memory.
// Define ENC_RANGE_CHECK_EN to flag immediates/targets that do not fit their encoded field.
module instr_encoder (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  base_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_class,
   input  logic [2:0]  in_rs,
   input  logic [2:0]  in_rt,
   input  logic [2:0]  in_rd,
   input  logic [15:0] in_imm,
   input  logic        in_last,
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [15:0] imem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [8:0]  word_count
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 9;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SLI = 3'd1;
   localparam logic [2:0] OP_J   = 3'd2;
   localparam logic [2:0] OP_JAL = 3'd3;

   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [CW-1:0] count_q, count_d;
   logic          last_q, last_d;
   logic          err_q, err_d;
   logic          in_ready_q, imem_we_q, busy_q, done_q;

   logic [DW-1:0] enc_word_c;
   logic          range_bad_c;

   // Field packing by instruction format
   always_comb begin : encode
      enc_word_c = '0;
      case (in_class)
         OP_ADD:       enc_word_c = {in_class, in_rs, in_rt, in_rd, 4'b0000};
         OP_J, OP_JAL: enc_word_c = {in_class, in_imm[12:0]};
         default:      enc_word_c = {in_class, in_rs, in_rt, in_imm[6:0]};
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   // Signed fields fit iff the bits above the field all match its sign bit
   always_comb begin : range_check
      range_bad_c = 1'b0;
      case (in_class)
         OP_ADD:       range_bad_c = 1'b0;
         OP_SLI:       range_bad_c = |in_imm[15:7];
         OP_J, OP_JAL: range_bad_c = |in_imm[15:13];
         default:      range_bad_c = !((in_imm[15:6] == '0) || (in_imm[15:6] == '1));
      endcase
   end
`else
   logic unused_imm_hi;
   assign unused_imm_hi = ^in_imm[15:13];
   assign range_bad_c   = 1'b0;
`endif

   always_comb begin : next_state
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      last_d  = last_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCEPT;
               addr_d  = base_addr;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         ACCEPT: begin
            if (in_valid && in_ready_q) begin
               wdata_d = enc_word_c;
               last_d  = in_last;
               err_d   = err_q | range_bad_c;
               state_d = WRITE;
            end
         end
         WRITE: begin
            count_d = count_q + CW'(1);
            addr_d  = addr_q + AW'(1);
            if (last_q) begin
               state_d = DONE;
            end else if (addr_q == '1) begin
               // Top of memory reached before the last word: end the session rather than wrap
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = ACCEPT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         count_q    <= '0;
         last_q     <= 1'b0;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
         imem_we_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         count_q    <= count_d;
         last_q     <= last_d;
         err_q      <= err_d;
         in_ready_q <= (state_d == ACCEPT);
         imem_we_q  <= (state_d == WRITE);
         busy_q     <= (state_d != IDLE);
         done_q     <= (state_d == DONE);
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_count = count_q;

endmodule
